// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core front end: next-PC control classes,
// fetch redirect states and the reset vector.
package cpu_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_op_e;

  typedef enum logic {
    FS_SEQ              = 1'b0,
    FS_REDIRECT_PENDING = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/npc_calc.sv
// Redirect target for the instruction currently in decode; purely combinational.
// Branch offsets are relative to the delay slot; jump regions come from the delay slot PC.
module npc_calc
  import cpu_pkg::*;
(
  input  logic [1:0]  npc_op,
  input  logic [31:0] pc_d,
  input  logic [15:0] imm16_d,
  input  logic [25:0] index26_d,
  input  logic [31:0] rs_data_d,
  output logic [31:0] target
);

  logic [31:0] pc4;
  logic        rs_lo_unused;

  assign pc4          = pc_d + 32'd4;
  // JR targets are silently word-aligned, so the low rs bits never matter.
  assign rs_lo_unused = ^rs_data_d[1:0];

  always_comb begin
    target = pc4 + {{14{imm16_d[15]}}, imm16_d, 2'b00};
    case (npc_op)
      NPC_J:   target = {pc4[31:28], index26_d, 2'b00};
      NPC_JR:  target = {rs_data_d[31:2], 2'b00};
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage and IF/ID register: PC, delay-slot aware redirects, imem wait states.
// A redirect seen while imem is busy is parked until the delay slot completes.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic        cmp_result,
  input  logic [15:0] imm16_d,
  input  logic [25:0] index26_d,
  input  logic [31:0] rs_data_d,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d
);

  logic [31:0]  pc_q;
  logic [31:0]  pend_tgt_q;
  fetch_state_e state_q;
  logic [31:0]  ifid_instr_q;
  logic [31:0]  ifid_pc_q;
  logic         ifid_vld_q;

  logic         fire;
  logic         redirect_now;
  logic [31:0]  target;
  logic [31:0]  pc_nxt_d;

  npc_calc u_npc_calc (
    .npc_op    (npc_op),
    .pc_d      (ifid_pc_q),
    .imm16_d   (imm16_d),
    .index26_d (index26_d),
    .rs_data_d (rs_data_d),
    .target    (target)
  );

  assign fire         = imem_ready & ~stall;
  assign redirect_now = ifid_vld_q & ~stall &
                        ((npc_op == NPC_J) | (npc_op == NPC_JR) |
                         ((npc_op == NPC_BR) & cmp_result));

  assign pc_nxt_d = redirect_now                        ? target     :
                    (state_q == FS_REDIRECT_PENDING)    ? pend_tgt_q :
                                                          pc_q + 32'd4;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= RESET_PC;
      pend_tgt_q   <= '0;
      state_q      <= FS_SEQ;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_vld_q   <= 1'b0;
    end else if (!stall) begin
      if (fire) begin
        pc_q         <= pc_nxt_d;
        state_q      <= FS_SEQ;
        ifid_instr_q <= imem_rdata;
        ifid_pc_q    <= pc_q;
        ifid_vld_q   <= 1'b1;
      end else begin
        // Delay slot still in flight: park the target, feed decode a bubble.
        if (redirect_now) begin
          state_q    <= FS_REDIRECT_PENDING;
          pend_tgt_q <= target;
        end
        ifid_instr_q <= '0;
        ifid_pc_q    <= pc_q;
        ifid_vld_q   <= 1'b0;
      end
    end
  end

  assign imem_addr = pc_q;
  assign instr_d   = ifid_instr_q;
  assign pc_d      = ifid_pc_q;
  assign pc8_d     = ifid_pc_q + 32'd8;
  assign valid_d   = ifid_vld_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: an architectural walk of each small program
// gives the expected decode stream, checked under various wait/stall patterns.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] IMEM_KEY = 32'h5A5A_0F0F;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  npc_op;
  logic        cmp_result;
  logic [15:0] imm16_d;
  logic [25:0] index26_d;
  logic [31:0] rs_data_d;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready = 1'b0;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        valid_d;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  op;
    logic        cmp;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs;
  } ctl_t;

  ctl_t        ctl [4];
  logic [31:0] exp_q [$];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic        last_vld;
  logic [31:0] last_pc;
  logic [31:0] last_instr;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall      (stall),
    .npc_op     (npc_op),
    .cmp_result (cmp_result),
    .imm16_d    (imm16_d),
    .index26_d  (index26_d),
    .rs_data_d  (rs_data_d),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc8_d      (pc8_d),
    .valid_d    (valid_d)
  );

  assign imem_rdata = imem_ready ? (imem_addr ^ IMEM_KEY) : 32'hDEAD_BEEF;

  // Decode stage stand-in: controls follow pc_d even for bubbles and stalls,
  // so the fetch unit has to ignore them there on its own.
  always_comb begin
    npc_op     = NPC_SEQ;
    cmp_result = 1'b0;
    imm16_d    = '0;
    index26_d  = '0;
    rs_data_d  = '0;
    for (int i = 0; i < 4; i++) begin
      if (ctl[i].pc == pc_d) begin
        npc_op     = ctl[i].op;
        cmp_result = ctl[i].cmp;
        imm16_d    = ctl[i].imm;
        index26_d  = ctl[i].idx;
        rs_data_d  = ctl[i].rs;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_ctl();
    for (int i = 0; i < 4; i++) begin
      ctl[i]    = '0;
      ctl[i].pc = 32'h0000_0001;
    end
  endtask

  task automatic set_ctl(input int i, input logic [31:0] pc, input logic [1:0] op,
                         input logic cmp, input logic [15:0] imm,
                         input logic [25:0] idx, input logic [31:0] rs);
    ctl[i] = '{pc: pc, op: op, cmp: cmp, imm: imm, idx: idx, rs: rs};
  endtask

  function automatic logic [31:0] target_of(input ctl_t c);
    logic [31:0] p4;
    p4 = c.pc + 32'd4;
    case (c.op)
      NPC_J:   return {p4[31:28], c.idx, 2'b00};
      NPC_JR:  return {c.rs[31:2], 2'b00};
      default: return p4 + {{14{c.imm[15]}}, c.imm, 2'b00};
    endcase
  endfunction

  // Architectural order of execution: a taken control transfer runs its delay slot first.
  task automatic build_stream(input logic [31:0] start, input int n);
    logic [31:0] pc;
    int          cnt;
    bit          tk;
    ctl_t        c;
    pc  = start;
    cnt = 0;
    while (cnt < n) begin
      exp_q.push_back(pc);
      cnt++;
      tk = 1'b0;
      c  = '0;
      for (int i = 0; i < 4; i++) begin
        if (ctl[i].pc == pc) begin
          c  = ctl[i];
          tk = (ctl[i].op == NPC_J) || (ctl[i].op == NPC_JR) ||
               ((ctl[i].op == NPC_BR) && ctl[i].cmp);
        end
      end
      if (tk) begin
        if (cnt < n) exp_q.push_back(pc + 32'd4);
        cnt++;
        pc = target_of(c);
      end else begin
        pc = pc + 32'd4;
      end
    end
  endtask

  task automatic do_reset();
    exp_q.delete();
    reset_n    = 1'b0;
    stall      = 1'b0;
    imem_ready = 1'b0;
    #2;
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_valid_d", {31'd0, valid_d}, 32'd0);
    chk("rst_instr_d", instr_d, 32'd0);
    chk("rst_pc_d", pc_d, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n    = 1'b1;
    last_vld   = 1'b0;
    last_pc    = '0;
    last_instr = '0;
  endtask

  task automatic run_scn(input logic [15:0] rdy_off, input logic [15:0] stl_on,
                         input bit rnd, input int stop_at);
    int          cyc;
    logic        pr;
    logic        ps;
    logic [31:0] e;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200 && !(stop_at > 0 && cyc >= stop_at)) begin
      if (rnd) begin
        imem_ready = ($urandom_range(0, 3) != 0);
        stall      = ($urandom_range(0, 4) == 0);
      end else begin
        imem_ready = (cyc < 16) ? ~rdy_off[cyc] : 1'b1;
        stall      = (cyc < 16) ? stl_on[cyc] : 1'b0;
      end
      pr = imem_ready;
      ps = stall;
      @(posedge clk);
      #1;
      if (!ps && pr) begin
        e = exp_q.pop_front();
        chk("dec_valid", {31'd0, valid_d}, 32'd1);
        chk("dec_pc", pc_d, e);
        chk("dec_instr", instr_d, e ^ IMEM_KEY);
        chk("dec_pc8", pc8_d, e + 32'd8);
        last_vld   = 1'b1;
        last_pc    = e;
        last_instr = e ^ IMEM_KEY;
      end else if (!ps) begin
        chk("bubble_valid", {31'd0, valid_d}, 32'd0);
        chk("bubble_instr", instr_d, 32'd0);
        chk("bubble_pc", pc_d, exp_q[0]);
        last_vld   = 1'b0;
        last_pc    = exp_q[0];
        last_instr = '0;
      end else begin
        chk("stall_valid", {31'd0, valid_d}, {31'd0, last_vld});
        chk("stall_pc", pc_d, last_pc);
        chk("stall_instr", instr_d, last_instr);
      end
      if (exp_q.size() > 0) chk("imem_addr", imem_addr, exp_q[0]);
      cyc++;
    end
    if (stop_at == 0) chk("drain_left", 32'(exp_q.size()), 32'd0);
    imem_ready = 1'b1;
    stall      = 1'b0;
  endtask

  initial begin
    clear_ctl();
    #1;

    // Straight-line fetch from the reset vector.
    do_reset();
    build_stream(RESET_PC, 6);
    run_scn(16'h0000, 16'h0000, 1'b0, 0);

    // Taken BEQ at 0x3000 to 0x3010, then the not-taken case.
    do_reset();
    set_ctl(0, 32'h3000, NPC_BR, 1'b1, 16'h0003, 26'd0, 32'd0);
    build_stream(RESET_PC, 5);
    run_scn(16'h0000, 16'h0000, 1'b0, 0);
    do_reset();
    ctl[0].cmp = 1'b0;
    build_stream(RESET_PC, 5);
    run_scn(16'h0000, 16'h0000, 1'b0, 0);

    // J to 0x3040, then JR with misaligned rs to 0x3104.
    clear_ctl();
    set_ctl(0, 32'h3020, NPC_J, 1'b0, 16'h0000, 26'h000_0C10, 32'd0);
    set_ctl(1, 32'h3044, NPC_JR, 1'b0, 16'h0000, 26'd0, 32'h0000_3107);
    do_reset();
    build_stream(RESET_PC, 15);
    run_scn(16'h0000, 16'h0000, 1'b0, 0);
    do_reset();
    build_stream(RESET_PC, 15);
    run_scn(16'h0000, 16'h0000, 1'b1, 0);

    // Branch to 0x3100 under wait states: bubble carrying the BR first, then 3 waits.
    clear_ctl();
    set_ctl(0, 32'h3000, NPC_BR, 1'b1, 16'h003F, 26'd0, 32'd0);
    do_reset();
    build_stream(RESET_PC, 4);
    run_scn(16'h001D, 16'h0000, 1'b0, 0);

    // Stall for 2 cycles with a taken BR in decode.
    clear_ctl();
    set_ctl(0, 32'h3000, NPC_BR, 1'b1, 16'h0003, 26'd0, 32'd0);
    do_reset();
    build_stream(RESET_PC, 5);
    run_scn(16'h0000, 16'h0006, 1'b0, 0);

    // Negative branch offset and 32-bit PC wrap.
    clear_ctl();
    set_ctl(0, 32'h3000, NPC_JR, 1'b0, 16'h0000, 26'd0, 32'h0000_7FF8);
    set_ctl(1, 32'h7FFC, NPC_BR, 1'b1, 16'h8000, 26'd0, 32'd0);
    set_ctl(2, 32'hFFFE_8004, NPC_JR, 1'b0, 16'h0000, 26'd0, 32'hFFFF_FFF8);
    do_reset();
    build_stream(RESET_PC, 12);
    run_scn(16'h0000, 16'h0000, 1'b0, 0);
    do_reset();
    build_stream(RESET_PC, 12);
    run_scn(16'h0000, 16'h0000, 1'b1, 0);

    // Reset while a redirect is parked must drop it.
    clear_ctl();
    set_ctl(0, 32'h3000, NPC_BR, 1'b1, 16'h003F, 26'd0, 32'd0);
    do_reset();
    build_stream(RESET_PC, 4);
    run_scn(16'h001D, 16'h0000, 1'b0, 4);
    do_reset();
    clear_ctl();
    build_stream(RESET_PC, 4);
    run_scn(16'h0000, 16'h0000, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
